// File: rtl/seq_chunk_adder_if.sv
// Handshake/operand/result bundle for seq_chunk_adder.
// Optional SAT input exists only when SEQ_CHUNK_ADDER_SAT_EN is defined.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;

  // Producer/consumer side (testbench or upstream datapath)
  modport master (
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    output sat,
`endif
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, busy
  );

  // Adder side
  modport slave (
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    input  sat,
`endif
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, busy
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock LSB-first, carry
// held in a register between slices. WIDTH must be a multiple of CHUNK.
// Optional signed saturation: define SEQ_CHUNK_ADDER_SAT_EN.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                         r_state, w_state_n;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_a, w_a_n;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_b, w_b_n;
  logic [NCHUNK-1:0][CHUNK-1:0]   r_s, w_s_n;
  logic                           r_carry, w_carry_n;
  logic [KW-1:0]                  r_k, w_k_n;
  logic                           r_cout, w_cout_n;
  logic                           r_ovf, w_ovf_n;
  logic                           r_zero, w_zero_n;
  logic                           r_out_valid, w_out_valid_n;
  logic                           r_busy, w_busy_n;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
  logic                           r_sat, w_sat_n;
`endif

  logic                           w_in_ready_c;
  logic                           w_accept;
  logic [CHUNK:0]                 w_sum;
  logic                           w_msb_cin;
  logic                           w_ovf;
  logic [NCHUNK-1:0][CHUNK-1:0]   w_s_upd;
  logic [NCHUNK-1:0][CHUNK-1:0]   w_s_fin;

  // Ready only when idle or when the held result retires this cycle
  assign w_in_ready_c = i_rst_n &&
                        ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
  assign w_accept     = bus.in_valid && w_in_ready_c;

  // Next-state and datapath next values
  always_comb begin
    w_state_n     = r_state;
    w_a_n         = r_a;
    w_b_n         = r_b;
    w_s_n         = r_s;
    w_carry_n     = r_carry;
    w_k_n         = r_k;
    w_cout_n      = r_cout;
    w_ovf_n       = r_ovf;
    w_zero_n      = r_zero;
    w_out_valid_n = r_out_valid;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    w_sat_n       = r_sat;
`endif

    // Current slice; on the last slice this is the MSB slice
    w_sum     = {1'b0, r_a[r_k]} + {1'b0, r_b[r_k]} + (CHUNK+1)'(r_carry);
    w_s_upd   = r_s;
    w_s_upd[r_k] = w_sum[CHUNK-1:0];
    w_msb_cin = r_a[NCHUNK-1][CHUNK-1] ^ r_b[NCHUNK-1][CHUNK-1] ^ w_sum[CHUNK-1];
    w_ovf     = w_msb_cin ^ w_sum[CHUNK];
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    // Overflow implies equal operand signs, so A's MSB picks the clamp direction
    if (r_sat && w_ovf)
      w_s_fin = {r_a[NCHUNK-1][CHUNK-1], {(WIDTH-1){~r_a[NCHUNK-1][CHUNK-1]}}};
    else
      w_s_fin = w_s_upd;
`else
    w_s_fin   = w_s_upd;
`endif

    case (r_state)
      S_IDLE: ;
      S_RUN: begin
        w_carry_n = w_sum[CHUNK];
        w_k_n     = r_k + KW'(1);
        w_s_n     = w_s_upd;
        if (r_k == KW'(NCHUNK-1)) begin
          w_s_n         = w_s_fin;
          w_cout_n      = w_sum[CHUNK];
          w_ovf_n       = w_ovf;
          w_zero_n      = (w_s_fin == '0);
          w_out_valid_n = 1'b1;
          w_state_n     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_out_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Accept overrides IDLE and retiring DONE; subtraction is A + ~B + ~borrow
    if (w_accept) begin
      w_a_n         = bus.a;
      w_b_n         = bus.sub ? ~bus.b : bus.b;
      w_carry_n     = bus.cin ^ bus.sub;
      w_k_n         = '0;
      w_out_valid_n = 1'b0;
      w_state_n     = S_RUN;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      w_sat_n       = bus.sat;
`endif
    end

    w_busy_n = (w_state_n != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_a         <= w_a_n;
      r_b         <= w_b_n;
      r_s         <= w_s_n;
      r_carry     <= w_carry_n;
      r_k         <= w_k_n;
      r_cout      <= w_cout_n;
      r_ovf       <= w_ovf_n;
      r_zero      <= w_zero_n;
      r_out_valid <= w_out_valid_n;
      r_busy      <= w_busy_n;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
      r_sat       <= w_sat_n;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready_c;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: main instance CHUNK=8, plus CHUNK=1
// and CHUNK=32 instances for the latency extremes.
module tb_seq_chunk_adder;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  seq_chunk_adder_if #(.WIDTH(W)) bus8 ();
  seq_chunk_adder_if #(.WIDTH(W)) bus1 ();
  seq_chunk_adder_if #(.WIDTH(W)) bus32 ();

  logic [31:0] aux_a, aux_b;
  logic        aux_cin, iv1, iv32, or1, or32;

  assign bus1.a = aux_a;   assign bus32.a = aux_a;
  assign bus1.b = aux_b;   assign bus32.b = aux_b;
  assign bus1.sub = 1'b0;  assign bus32.sub = 1'b0;
  assign bus1.cin = aux_cin; assign bus32.cin = aux_cin;
  assign bus1.in_valid = iv1;  assign bus32.in_valid = iv32;
  assign bus1.out_ready = or1; assign bus32.out_ready = or32;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
  assign bus1.sat = 1'b0;  assign bus32.sat = 1'b0;
`endif

  seq_chunk_adder #(.WIDTH(W), .CHUNK(8))  u_dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(1))  u_dut1  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the CHUNK=8 instance, starting from IDLE
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, input logic sat,
                       input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    int cyc;
    bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.cin = cin;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    bus8.sat = sat;
`else
    if (sat) $display("note: %s sat request ignored in this build", tag);
`endif
    bus8.in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, bus8.in_ready, 1'b1);
    tick;
    bus8.in_valid = 1'b0;
    // Operands after accept must not matter
    bus8.a = ~a; bus8.b = ~b; bus8.sub = ~sub; bus8.cin = ~cin;
    chk({tag, ".busy_run"}, bus8.busy, 1'b1);
    chk({tag, ".in_ready_run"}, bus8.in_ready, 1'b0);
    cyc = 0;
    while (!bus8.out_valid && cyc < 200) begin
      tick;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, 4);
    chk({tag, ".s"}, bus8.s, es);
    chk({tag, ".cout"}, bus8.cout, ec);
    chk({tag, ".ovf"}, bus8.ovf, eo);
    chk({tag, ".zero"}, bus8.zero, ez);
    bus8.out_ready = 1'b1;
    tick;
    bus8.out_ready = 1'b0;
    chk({tag, ".ov_drop"}, bus8.out_valid, 1'b0);
    chk({tag, ".busy_idle"}, bus8.busy, 1'b0);
  endtask

  // Addition on the CHUNK=1 (sel=1) or CHUNK=32 (sel=32) instance
  task automatic run_aux(input string tag, input int sel, input logic [31:0] a,
                         input logic [31:0] b, input logic cin,
                         input logic [31:0] es, input logic ec, input int elat);
    int cyc;
    aux_a = a; aux_b = b; aux_cin = cin;
    if (sel == 1) iv1 = 1'b1; else iv32 = 1'b1;
    tick;
    iv1 = 1'b0; iv32 = 1'b0;
    aux_a = ~a; aux_b = ~b; aux_cin = ~cin;
    cyc = 0;
    while (!((sel == 1) ? bus1.out_valid : bus32.out_valid) && cyc < 200) begin
      tick;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, elat);
    chk({tag, ".s"}, (sel == 1) ? bus1.s : bus32.s, es);
    chk({tag, ".cout"}, (sel == 1) ? bus1.cout : bus32.cout, ec);
    if (sel == 1) or1 = 1'b1; else or32 = 1'b1;
    tick;
    or1 = 1'b0; or32 = 1'b0;
  endtask

  initial begin
    int cyc;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0; bus8.cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    bus8.sat = 1'b0;
`endif
    aux_a = '0; aux_b = '0; aux_cin = 1'b0;
    iv1 = 1'b0; iv32 = 1'b0; or1 = 1'b0; or32 = 1'b0;

    // Reset state
    #12;
    chk("rst.out_valid", bus8.out_valid, 1'b0);
    chk("rst.busy", bus8.busy, 1'b0);
    chk("rst.in_ready", bus8.in_ready, 1'b0);
    chk("rst.s", bus8.s, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Basic add, carry across one slice boundary
    do_op("s1", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    // Carry through every slice
    do_op("s2a", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_op("s2b", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    // Signed overflow, wrapping
    do_op("s3a", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    do_op("s3b", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_op("s3c", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    do_op("s3c", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
    // Subtraction with borrow
    do_op("s4a", 32'h5, 32'h7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("s4b", 32'h7, 32'h5, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);

    // Backpressure then back-to-back accept
    bus8.a = 32'h10; bus8.b = 32'h20; bus8.sub = 1'b0; bus8.cin = 1'b0;
    bus8.in_valid = 1'b1;
    tick;
    bus8.in_valid = 1'b0;
    cyc = 0;
    while (!bus8.out_valid && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("s5.lat1", cyc, 4);
    bus8.a = 32'h3; bus8.b = 32'h4; bus8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("s5.hold_s", bus8.s, 32'h30);
      chk("s5.hold_ov", bus8.out_valid, 1'b1);
      chk("s5.hold_rdy", bus8.in_ready, 1'b0);
    end
    chk("s5.hold_flags", {bus8.cout, bus8.ovf, bus8.zero}, 3'b000);
    bus8.out_ready = 1'b1;
    #1;
    chk("s5.rdy_b2b", bus8.in_ready, 1'b1);
    tick;
    bus8.out_ready = 1'b0; bus8.in_valid = 1'b0;
    chk("s5.ov_drop", bus8.out_valid, 1'b0);
    chk("s5.busy", bus8.busy, 1'b1);
    cyc = 0;
    while (!bus8.out_valid && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("s5.lat2", cyc, 4);
    chk("s5.s2", bus8.s, 32'h7);
    bus8.out_ready = 1'b1;
    tick;
    bus8.out_ready = 1'b0;
    chk("s5.retire", bus8.out_valid, 1'b0);

    // Reset in the middle of RUN
    bus8.a = 32'h1234_5678; bus8.b = 32'h1111_1111; bus8.in_valid = 1'b1;
    tick;
    bus8.in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("s6.s", bus8.s, 32'h0);
    chk("s6.ov", bus8.out_valid, 1'b0);
    chk("s6.busy", bus8.busy, 1'b0);
    chk("s6.flags", {bus8.cout, bus8.ovf, bus8.zero}, 3'b000);
    chk("s6.rdy", bus8.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    do_op("s6.s1", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    // Latency extremes
    run_aux("c1.s1", 1, 32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 32);
    run_aux("c1.s2", 1, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 32);
    run_aux("c32.s1", 32, 32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 1);
    run_aux("c32.s2", 32, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
